wimax_stream_checker: RTL and testbench
=======================================

# wimax_stream_checker

Multi-channel, parametrised golden-pattern checker for the WiMAX transmit chain (PRBS, FEC, interleaver and modulator bit streams). Each channel compares its incoming valid-qualified bit stream against a per-channel golden frame. Each channel also reports:
- per-bit match
- per-frame pass/fail
- saturating error and frame counts
- lock status after consecutive clean frames

It sits beside the transmit chain in self-test builds. It replaces fixed per-stage compare logic with a single reusable block.

## Interface
- NUM_CH, 2: number of independent channels (≥1).
- MAX_LEN, 192: golden frame storage per channel, in bits (≥2).
- CH_LEN, {16'd192,16'd96}: packed per-channel frame length; channel c is CH_LEN[c*16 +: 16]; each value must be 1..MAX_LEN.
- GOLDEN, all zeros: [0:NUM_CH*MAX_LEN-1]; channel c bit i is GOLDEN[c*MAX_LEN+i]; bit 0 is compared first.
- CNT_W, 16: width of the error and frame counters.
- LOCK_FRAMES, 2: number of consecutive passing frames needed to declare lock (≥1).

Ports:
- clk_ref  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all channels.
- valid_in  in  NUM_CH  per-channel beat qualifier.
- data_in  in  NUM_CH  per-channel data bit.
- bit_ok  out  NUM_CH  registered result of the last compared beat.
- frame_done  out  NUM_CH  one-cycle pulse after the last beat of a frame.
- frame_pass  out  NUM_CH  result of the last completed frame.
- locked  out  NUM_CH  channel lock status.
- all_locked  out  1  AND of all locked bits.
- err_count  out  NUM_CH*CNT_W  saturating mismatch count; channel c is at [c*CNT_W +: CNT_W].
- frame_count  out  NUM_CH*CNT_W  saturating count of completed frames; same packing as err_count.

## Operation
- Channels are fully independent. Each channel has:
  - a bit index, $clog2(MAX_LEN) bits wide
  - an in-frame error flag
  - a consecutive-pass counter
  - a state machine with states IDLE, CHECK, LOCKED
- Reset: every output is 0, every index is 0, and every state is IDLE.
- Per valid beat (valid_in[c]=1):
  - match = (data_in[c] == GOLDEN[c*MAX_LEN+idx]).
  - bit_ok[c] <= match.
  - On mismatch: err_count increments, saturating at 2^CNT_W−1, and the in-frame error flag is set.
- Index handling:
  - The index increments on each valid beat.
  - When the index equals CH_LEN[c]−1, it wraps to 0 and the beat is the frame end.
  - With no valid beat, the index, bit_ok and all other state hold. Gaps in valid do not break a frame.
- At a frame end:
  - frame_done[c] pulses.
  - frame_pass[c] <= no mismatch anywhere in the frame, including the final beat.
  - frame_count increments, saturating.
  - The in-frame error flag is cleared for the next frame.
- State machine:
  - IDLE → CHECK on the first valid beat. That beat is compared as bit 0.
  - In CHECK, a passing frame increments the pass counter; a failing frame zeroes it.
  - CHECK → LOCKED when the pass counter reaches LOCK_FRAMES. locked[c]=1 in LOCKED.
  - LOCKED → CHECK on any failing frame; the pass counter is zeroed.
  - Mismatches inside a frame do not change the state until frame end.
  - LOCKED stays LOCKED on passing frames.
- CH_LEN=1: every beat is a frame end.
- clear=1:
  - All channels return to the reset condition on the next edge: outputs 0, index 0, state IDLE.
  - clear takes priority over a simultaneous valid beat; that beat is discarded and is not counted.
- all_locked is the combinational AND of the registered locked bits. It adds no extra latency.

## Timing
- Beat sampled at edge N: bit_ok, err_count, frame_done, frame_pass, frame_count and locked are visible after edge N. This is 1-cycle latency.
- frame_done is high for exactly one cycle per frame. Back-to-back frames give pulses in consecutive frame-end cycles.
- When lock is reached, locked rises in the same cycle as the frame_done of the LOCK_FRAMES-th clean frame.
- When lock is lost, locked falls in the same cycle as the frame_done of the failing frame.
- Asserting rst_n low mid-frame clears everything immediately, without waiting for a clock edge. After release, the first beat is compared as bit 0.

## Test plan
Bench configuration: NUM_CH=2, MAX_LEN=8, CH_LEN ch0=4 and ch1=8, GOLDEN=16'b1010_0000_1100_1010, LOCK_FRAMES=2.

- Reset: all outputs read 0 after rst_n is released.
- Clean stream: ch0 gets 1,0,1,0 repeated with continuous valid.
  - bit_ok stays 1.
  - frame_done pulses one cycle after beats 3 and 7.
  - frame_pass=1.
  - locked rises with the second pulse; frame_count=2.
- Gapped stream: ch1 gets 11001010 with valid deasserted for 3 cycles after beat 4.
  - The index holds during the gap.
  - frame_pass=1, err_count=0.
  - ch0 is unaffected.
- Error then lock loss:
  - Lock ch0 first.
  - Send frame 1,0,0,0: bit_ok=0 after beat 2, err_count=1.
  - At that frame's frame_done: frame_pass=0, locked=0.
  - Two further clean frames re-lock the channel.
- Saturation (CNT_W=4): drive ch1 with inverted data for 20 beats.
  - err_count reaches 15 and holds there.
  - frame_count=2.
- Clear and reset mid-frame:
  - Assert clear together with a valid beat at ch0 index 2. The beat is ignored; counters and index read 0.
  - The next beat, value 1, gives bit_ok=1 (compared as bit 0).
  - Repeat using rst_n instead of clear: outputs clear asynchronously.

Source files
------------

// File: rtl/wimax_stream_checker.sv
// wimax_stream_checker: per-channel golden-pattern compare with frame pass/fail,
// saturating error/frame counters and lock tracking over consecutive clean frames.
module wimax_stream_checker #(
  parameter int unsigned          NUM_CH      = 2,
  parameter int unsigned          MAX_LEN     = 192,
  parameter logic [NUM_CH*16-1:0] CH_LEN      = {16'd192, 16'd96},
  parameter logic [0:NUM_CH*MAX_LEN-1] GOLDEN = '0,
  parameter int unsigned          CNT_W       = 16,
  parameter int unsigned          LOCK_FRAMES = 2
) (
  input  logic                    clk_ref,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       valid_in,
  input  logic [NUM_CH-1:0]       data_in,
  output logic [NUM_CH-1:0]       bit_ok,
  output logic [NUM_CH-1:0]       frame_done,
  output logic [NUM_CH-1:0]       frame_pass,
  output logic [NUM_CH-1:0]       locked,
  output logic                    all_locked,
  output logic [NUM_CH*CNT_W-1:0] err_count,
  output logic [NUM_CH*CNT_W-1:0] frame_count
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN);
  localparam int unsigned PC_W  = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_LEN[c*16 +: 16] - 16'd1);
    localparam int unsigned      BASE     = c * MAX_LEN;

    logic [IDX_W-1:0] r_idx;
    logic             r_err_flag;
    logic [PC_W-1:0]  r_pass_cnt;
    state_t           r_state;
    logic             r_bit_ok;
    logic             r_frame_done;
    logic             r_frame_pass;
    logic             r_locked;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_frame_cnt;

    logic             w_gold;
    logic             w_match;
    logic             w_last;
    logic             w_frame_ok;
    logic [PC_W-1:0]  w_pass_inc;

    // Golden bit for the current index, and per-beat frame bookkeeping
    assign w_gold     = GOLDEN[BASE + 32'(r_idx)];
    assign w_match    = (data_in[c] == w_gold);
    assign w_last     = (r_idx == LAST_IDX);
    assign w_frame_ok = ~r_err_flag & w_match;
    assign w_pass_inc = r_pass_cnt + PC_W'(1);

    // Channel state: index, counters, frame result and lock state machine
    always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
        r_idx        <= '0;
        r_err_flag   <= 1'b0;
        r_pass_cnt   <= '0;
        r_state      <= ST_IDLE;
        r_bit_ok     <= 1'b0;
        r_frame_done <= 1'b0;
        r_frame_pass <= 1'b0;
        r_locked     <= 1'b0;
        r_err_cnt    <= '0;
        r_frame_cnt  <= '0;
      end else if (clear) begin
        r_idx        <= '0;
        r_err_flag   <= 1'b0;
        r_pass_cnt   <= '0;
        r_state      <= ST_IDLE;
        r_bit_ok     <= 1'b0;
        r_frame_done <= 1'b0;
        r_frame_pass <= 1'b0;
        r_locked     <= 1'b0;
        r_err_cnt    <= '0;
        r_frame_cnt  <= '0;
      end else begin
        r_frame_done <= 1'b0;
        if (valid_in[c]) begin
          r_bit_ok <= w_match;
          if (!w_match && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
          end
          if (w_last) begin
            r_idx        <= '0;
            r_err_flag   <= 1'b0;
            r_frame_done <= 1'b1;
            r_frame_pass <= w_frame_ok;
            if (r_frame_cnt != '1) begin
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            case (r_state)
              ST_LOCKED: begin
                if (!w_frame_ok) begin
                  r_state    <= ST_CHECK;
                  r_pass_cnt <= '0;
                  r_locked   <= 1'b0;
                end
              end
              default: begin
                if (!w_frame_ok) begin
                  r_state    <= ST_CHECK;
                  r_pass_cnt <= '0;
                end else if (w_pass_inc >= PC_W'(LOCK_FRAMES)) begin
                  r_state    <= ST_LOCKED;
                  r_pass_cnt <= w_pass_inc;
                  r_locked   <= 1'b1;
                end else begin
                  r_state    <= ST_CHECK;
                  r_pass_cnt <= w_pass_inc;
                end
              end
            endcase
          end else begin
            r_idx <= r_idx + IDX_W'(1);
            if (!w_match) begin
              r_err_flag <= 1'b1;
            end
            if (r_state == ST_IDLE) begin
              r_state <= ST_CHECK;
            end
          end
        end
      end
    end

    assign bit_ok[c]                         = r_bit_ok;
    assign frame_done[c]                     = r_frame_done;
    assign frame_pass[c]                     = r_frame_pass;
    assign locked[c]                         = r_locked;
    assign err_count[c*CNT_W +: CNT_W]       = r_err_cnt;
    assign frame_count[c*CNT_W +: CNT_W]     = r_frame_cnt;
  end

  // Aggregate lock, taken straight from the registered per-channel bits
  assign all_locked = &locked;

endmodule

// File: tb/tb_wimax_stream_checker.sv
// Directed, table-driven bench for wimax_stream_checker (2 channels, lengths 4 and 8, 4-bit counters).
module tb_wimax_stream_checker;

  logic       clk_ref = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clear   = 1'b0;
  logic [1:0] valid_in = '0;
  logic [1:0] data_in  = '0;
  logic [1:0] bit_ok, frame_done, frame_pass, locked;
  logic       all_locked;
  logic [7:0] err_count, frame_count;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string      nm;
    logic [1:0] v;
    logic [1:0] d;
    logic       clr;
    logic [1:0] ok;
    logic [1:0] fd;
    logic [1:0] fp;
    logic [1:0] lk;
    logic       al;
    logic [7:0] err;
    logic [7:0] fc;
  } vec_t;

  vec_t vq[$];

  wimax_stream_checker #(
    .NUM_CH      (2),
    .MAX_LEN     (8),
    .CH_LEN      ({16'd8, 16'd4}),
    .GOLDEN      (16'b1010_0000_1100_1010),
    .CNT_W       (4),
    .LOCK_FRAMES (2)
  ) dut (
    .clk_ref     (clk_ref),
    .rst_n       (rst_n),
    .clear       (clear),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .bit_ok      (bit_ok),
    .frame_done  (frame_done),
    .frame_pass  (frame_pass),
    .locked      (locked),
    .all_locked  (all_locked),
    .err_count   (err_count),
    .frame_count (frame_count)
  );

  always #5 clk_ref = ~clk_ref;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [1:0] v, input logic [1:0] d, input logic clr,
                     input logic [1:0] ok, input logic [1:0] fd, input logic [1:0] fp,
                     input logic [1:0] lk, input logic al, input logic [7:0] err, input logic [7:0] fc);
    vec_t t;
    t.nm = nm; t.v = v; t.d = d; t.clr = clr; t.ok = ok; t.fd = fd; t.fp = fp;
    t.lk = lk; t.al = al; t.err = err; t.fc = fc;
    vq.push_back(t);
  endtask

  // One clean ch0 frame (1,0,1,0); ch1 stays idle at zero
  task automatic add_clean0(input string nm, input logic fp_before, input logic lk_before,
                            input logic lk_after, input logic [3:0] fc_after, input logic [3:0] err0);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] d;
      d = {1'b0, (i % 2 == 0)};
      if (i < 3)
        add($sformatf("%s_b%0d", nm, i), 2'b01, d, 1'b0, 2'b01, 2'b00, {1'b0, fp_before},
            {1'b0, lk_before}, 1'b0, {4'h0, err0}, {4'h0, fc_after - 4'd1});
      else
        add($sformatf("%s_b%0d", nm, i), 2'b01, d, 1'b0, 2'b01, 2'b01, 2'b01,
            {1'b0, lk_after}, 1'b0, {4'h0, err0}, {4'h0, fc_after});
    end
  endtask

  task automatic check_outs(input string nm, input vec_t t);
    chk({nm, ".bit_ok"},      32'(bit_ok),      32'(t.ok));
    chk({nm, ".frame_done"},  32'(frame_done),  32'(t.fd));
    chk({nm, ".frame_pass"},  32'(frame_pass),  32'(t.fp));
    chk({nm, ".locked"},      32'(locked),      32'(t.lk));
    chk({nm, ".all_locked"},  32'(all_locked),  32'(t.al));
    chk({nm, ".err_count"},   32'(err_count),   32'(t.err));
    chk({nm, ".frame_count"}, 32'(frame_count), 32'(t.fc));
  endtask

  // Apply every queued vector on successive edges and compare 1 ns after each edge
  task automatic run();
    for (int i = 0; i < vq.size(); i++) begin
      valid_in = vq[i].v;
      data_in  = vq[i].d;
      clear    = vq[i].clr;
      @(posedge clk_ref);
      #1;
      check_outs(vq[i].nm, vq[i]);
    end
    valid_in = '0;
    data_in  = '0;
    clear    = 1'b0;
    vq.delete();
  endtask

  task automatic do_reset(input string nm);
    vec_t z;
    z.nm = nm; z.v = '0; z.d = '0; z.clr = 1'b0; z.ok = '0; z.fd = '0; z.fp = '0;
    z.lk = '0; z.al = 1'b0; z.err = '0; z.fc = '0;
    valid_in = '0;
    data_in  = '0;
    clear    = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk_ref);
    #1;
    rst_n = 1'b1;
    @(posedge clk_ref);
    #1;
    check_outs(nm, z);
  endtask

  logic [7:0] g1;

  initial begin
    g1 = 8'b1100_1010;

    // Reset state
    do_reset("rst0");

    // Clean ch0 stream, lock on second frame
    add_clean0("t1_f0", 1'b0, 1'b0, 1'b0, 4'd1, 4'd0);
    add_clean0("t1_f1", 1'b1, 1'b0, 1'b1, 4'd2, 4'd0);
    add("t1_idle", 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0, 8'h00, 8'h02);
    run();

    // Gapped ch1 frame; junk data during the gap must be ignored
    for (int i = 0; i < 5; i++)
      add($sformatf("t2_b%0d", i), 2'b10, {g1[7-i], 1'b0}, 1'b0, 2'b11, 2'b00, 2'b01, 2'b01, 1'b0, 8'h00, 8'h02);
    for (int i = 0; i < 3; i++)
      add($sformatf("t2_gap%0d", i), 2'b00, 2'b10, 1'b0, 2'b11, 2'b00, 2'b01, 2'b01, 1'b0, 8'h00, 8'h02);
    add("t2_b5", 2'b10, 2'b00, 1'b0, 2'b11, 2'b00, 2'b01, 2'b01, 1'b0, 8'h00, 8'h02);
    add("t2_b6", 2'b10, 2'b10, 1'b0, 2'b11, 2'b00, 2'b01, 2'b01, 1'b0, 8'h00, 8'h02);
    add("t2_b7", 2'b10, 2'b00, 1'b0, 2'b11, 2'b10, 2'b11, 2'b01, 1'b0, 8'h00, 8'h12);
    // Second clean ch1 frame locks ch1 and raises all_locked
    for (int i = 0; i < 8; i++) begin
      if (i < 7)
        add($sformatf("t2_c%0d", i), 2'b10, {g1[7-i], 1'b0}, 1'b0, 2'b11, 2'b00, 2'b11, 2'b01, 1'b0, 8'h00, 8'h12);
      else
        add($sformatf("t2_c%0d", i), 2'b10, {g1[7-i], 1'b0}, 1'b0, 2'b11, 2'b10, 2'b11, 2'b11, 1'b1, 8'h00, 8'h22);
    end
    run();

    // Error frame drops lock, two clean frames re-lock
    do_reset("rst3");
    add_clean0("t3_f0", 1'b0, 1'b0, 1'b0, 4'd1, 4'd0);
    add_clean0("t3_f1", 1'b1, 1'b0, 1'b1, 4'd2, 4'd0);
    add("t3_e0", 2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0, 8'h00, 8'h02);
    add("t3_e1", 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0, 8'h00, 8'h02);
    add("t3_e2", 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0, 8'h01, 8'h02);
    add("t3_e3", 2'b01, 2'b00, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 8'h01, 8'h03);
    add_clean0("t3_r0", 1'b0, 1'b0, 1'b0, 4'd4, 4'd1);
    add_clean0("t3_r1", 1'b1, 1'b0, 1'b1, 4'd5, 4'd1);
    run();

    // Error counter saturation on ch1 with inverted data
    do_reset("rst4");
    for (int i = 0; i < 20; i++) begin
      logic [3:0] e;
      logic [3:0] f;
      logic [1:0] fd;
      e  = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      f  = (i >= 15) ? 4'd2 : ((i >= 7) ? 4'd1 : 4'd0);
      fd = (i == 7 || i == 15) ? 2'b10 : 2'b00;
      add($sformatf("t4_b%0d", i), 2'b10, {~g1[7-(i%8)], 1'b0}, 1'b0, 2'b00, fd, 2'b00, 2'b00, 1'b0,
          {e, 4'h0}, {f, 4'h0});
    end
    run();

    // Synchronous clear beats a simultaneous valid beat
    do_reset("rst5");
    add("t5_b0",  2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00);
    add("t5_b1",  2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h01, 8'h00);
    add("t5_clr", 2'b01, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00);
    add("t5_q0",  2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00);
    add("t5_q1",  2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00);
    add("t5_q2",  2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00);
    add("t5_q3",  2'b01, 2'b00, 1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 8'h00, 8'h01);
    run();

    // Asynchronous reset mid-frame, no clock edge in between
    do_reset("rst6");
    add("t6_b0", 2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00);
    add("t6_b1", 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h01, 8'h00);
    add("t6_b2", 2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h01, 8'h00);
    run();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async.bit_ok",    32'(bit_ok),      32'h0);
    chk("t6_async.err_count", 32'(err_count),   32'h0);
    #1;
    rst_n = 1'b1;
    add("t6_q0", 2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00);
    add("t6_q1", 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00);
    add("t6_q2", 2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00);
    add("t6_q3", 2'b01, 2'b00, 1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 8'h00, 8'h01);
    run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
